sample_walker: RTL and testbench

Synthesizable sample-iteration block between bounding-box generation and sample test in the rasterizer pipeline. It accepts one triangle at a time with its clipped bounding box and emits every subsample position inside that box in raster order, one per cycle. It stalls upstream with `halt_RnnnnL` while iterating. Its output stream (`tri_R14S`, `color_R14U`, `sample_R14S`, `validSamp_R14H`) is the traffic that the sample-count and sample-test scoreboards consume downstream.

---
 rtl/sample_walker.sv | 145 ++++++++++++++
 tb/tb_sample_walker.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_walker.sv
// Walks every subsample position of a triangle's clipped bounding box in raster order,
// one per cycle, holding off upstream until the final sample of the box is emitted.
module sample_walker #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
  input  logic        [COLORS-1:0][SIGFIG-1:0]          color_R13U,
  input  logic signed [1:0][1:0][SIGFIG-1:0]            box_R13S,
  input  logic                                          validTri_R13H,
  input  logic        [3:0]                             subSample_RnnnnU,
  output logic                                          halt_RnnnnL,
  output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
  output logic        [COLORS-1:0][SIGFIG-1:0]          color_R14U,
  output logic signed [1:0][SIGFIG-1:0]                 sample_R14S,
  output logic                                          validSamp_R14H,
  output logic                                          lastSamp_R14H,
  output logic        [31:0]                            sampIdx_R14U
);

  typedef enum logic {ST_WAIT = 1'b0, ST_TEST = 1'b1} state_t;

  state_t state_q, state_d;

  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q, tri_d;
  logic [COLORS-1:0][SIGFIG-1:0]          color_q, color_d;
  logic [SIGFIG-1:0] llx_q, llx_d, urx_q, urx_d, ury_q, ury_d;
  logic [SIGFIG-1:0] step_q, step_d;
  logic [SIGFIG-1:0] x_q, x_d, y_q, y_d;
  logic [31:0]       idx_q, idx_d;

  logic [1:0]         ss_w_lg2;
  logic [SIGFIG-1:0]  step_new;
  logic signed [SIGFIG:0] x_sum, y_sum;
  logic x_fits, y_fits, at_end, accept, box_empty;

  always_comb begin
    if (subSample_RnnnnU[0])      ss_w_lg2 = 2'd3;
    else if (subSample_RnnnnU[1]) ss_w_lg2 = 2'd2;
    else if (subSample_RnnnnU[2]) ss_w_lg2 = 2'd1;
    else if (subSample_RnnnnU[3]) ss_w_lg2 = 2'd0;
    else                          ss_w_lg2 = 2'd0;
  end

  assign step_new = {{(SIGFIG-1){1'b0}}, 1'b1} << (RADIX - int'(ss_w_lg2));

  // One extra bit keeps a box near the positive limit from wrapping back inside.
  assign x_sum  = $signed({x_q[SIGFIG-1], x_q}) + $signed({1'b0, step_q});
  assign y_sum  = $signed({y_q[SIGFIG-1], y_q}) + $signed({1'b0, step_q});
  assign x_fits = x_sum <= $signed({urx_q[SIGFIG-1], urx_q});
  assign y_fits = y_sum <= $signed({ury_q[SIGFIG-1], ury_q});
  assign at_end = (state_q == ST_TEST) && !x_fits && !y_fits;

  assign box_empty = ($signed(box_R13S[0][0]) > $signed(box_R13S[1][0])) ||
                     ($signed(box_R13S[0][1]) > $signed(box_R13S[1][1]));
  assign accept    = validTri_R13H && halt_RnnnnL;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_WAIT;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT: if (accept && !box_empty) state_d = ST_TEST;
      ST_TEST: if (at_end) state_d = (accept && !box_empty) ? ST_TEST : ST_WAIT;
      default: state_d = ST_WAIT;
    endcase
  end

  always_comb begin
    halt_RnnnnL    = (state_q == ST_WAIT) || at_end;
    validSamp_R14H = (state_q == ST_TEST);
    lastSamp_R14H  = at_end;
  end

  always_comb begin
    tri_d   = tri_q;
    color_d = color_q;
    llx_d   = llx_q;
    urx_d   = urx_q;
    ury_d   = ury_q;
    step_d  = step_q;
    x_d     = x_q;
    y_d     = y_q;
    idx_d   = idx_q;
    if (accept) begin
      tri_d   = tri_R13S;
      color_d = color_R13U;
      llx_d   = box_R13S[0][0];
      urx_d   = box_R13S[1][0];
      ury_d   = box_R13S[1][1];
      step_d  = step_new;
      if (!box_empty) begin
        x_d   = box_R13S[0][0];
        y_d   = box_R13S[0][1];
        idx_d = 32'd0;
      end
    end else if ((state_q == ST_TEST) && !at_end) begin
      idx_d = idx_q + 32'd1;
      if (x_fits) begin
        x_d = x_sum[SIGFIG-1:0];
      end else begin
        x_d = llx_q;
        y_d = y_sum[SIGFIG-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tri_q   <= '0;
      color_q <= '0;
      llx_q   <= '0;
      urx_q   <= '0;
      ury_q   <= '0;
      step_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      idx_q   <= '0;
    end else begin
      tri_q   <= tri_d;
      color_q <= color_d;
      llx_q   <= llx_d;
      urx_q   <= urx_d;
      ury_q   <= ury_d;
      step_q  <= step_d;
      x_q     <= x_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
    end
  end

  assign tri_R14S     = tri_q;
  assign color_R14U   = color_q;
  assign sample_R14S  = {y_q, x_q};
  assign sampIdx_R14U = idx_q;

endmodule

// File: tb/tb_sample_walker.sv
// Scoreboarded bench for sample_walker: expected samples are queued when a triangle
// is driven and popped by a monitor as the walker emits them.
module tb_sample_walker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0][2:0][23:0] tri_in, tri_out;
  logic [2:0][23:0]      color_in, color_out;
  logic [1:0][1:0][23:0] box_in;
  logic                  valid_tri;
  logic [3:0]            sub_sample;
  logic                  halt;
  logic [1:0][23:0]      sample_out;
  logic                  valid_samp, last_samp;
  logic [31:0]           samp_idx;

  int checks = 0;
  int passed = 0;

  typedef struct {
    int x;
    int y;
    int idx;
    bit last;
    int tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  sample_walker dut (
    .clk              (clk),
    .rst              (rst),
    .tri_R13S         (tri_in),
    .color_R13U       (color_in),
    .box_R13S         (box_in),
    .validTri_R13H    (valid_tri),
    .subSample_RnnnnU (sub_sample),
    .halt_RnnnnL      (halt),
    .tri_R14S         (tri_out),
    .color_R14U       (color_out),
    .sample_R14S      (sample_out),
    .validSamp_R14H   (valid_samp),
    .lastSamp_R14H    (last_samp),
    .sampIdx_R14U     (samp_idx)
  );

  always #5 clk = ~clk;

  // Reference raster walk over the box using wide integers.
  function automatic void model_box(input int tag, input longint llx, input longint lly,
                                    input longint urx, input longint ury, input longint step);
    int n = 0;
    for (longint y = lly; y <= ury; y += step) begin
      for (longint x = llx; x <= urx; x += step) begin
        exp_t e;
        e.x    = int'(x);
        e.y    = int'(y);
        e.idx  = n;
        e.last = (x + step > urx) && (y + step > ury);
        e.tag  = tag;
        exp_q.push_back(e);
        n++;
      end
    end
  endfunction

  task automatic drive_tri(input int tag, input int llx, input int lly,
                           input int urx, input int ury, input logic [3:0] ss);
    for (int v = 0; v < 3; v++)
      for (int a = 0; a < 3; a++)
        tri_in[v][a] = 24'(tag * 16 + v * 4 + a);
    for (int c = 0; c < 3; c++) color_in[c] = 24'(tag * 8 + c);
    box_in[0][0] = 24'(llx);
    box_in[0][1] = 24'(lly);
    box_in[1][0] = 24'(urx);
    box_in[1][1] = 24'(ury);
    sub_sample   = ss;
    valid_tri    = 1'b1;
  endtask

  always @(negedge clk) begin
    if (valid_samp) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_sample: got x=%0d y=%0d idx=%0d, required no sample",
                 $signed(sample_out[0]), $signed(sample_out[1]), samp_idx);
      end else begin
        mon_e = exp_q.pop_front();
        if ($signed(sample_out[0]) !== mon_e.x || $signed(sample_out[1]) !== mon_e.y ||
            samp_idx !== 32'(mon_e.idx) || last_samp !== mon_e.last ||
            tri_out[0][0] !== 24'(mon_e.tag * 16) || color_out[0] !== 24'(mon_e.tag * 8)) begin
          $display("FAIL sample: got x=%0d y=%0d idx=%0d last=%0b tri=%0d col=%0d, required x=%0d y=%0d idx=%0d last=%0b tri=%0d col=%0d",
                   $signed(sample_out[0]), $signed(sample_out[1]), samp_idx, last_samp,
                   tri_out[0][0], color_out[0], mon_e.x, mon_e.y, mon_e.idx, mon_e.last,
                   mon_e.tag * 16, mon_e.tag * 8);
        end else begin
          passed++;
          $display("sample tag=%0d idx=%0d (%0d,%0d) last=%0b", mon_e.tag, mon_e.idx,
                   mon_e.x, mon_e.y, mon_e.last);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    valid_tri = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (valid_samp !== 1'b0 || halt !== 1'b1 || last_samp !== 1'b0) begin
      $display("FAIL reset_ctrl: got valid=%0b halt=%0b last=%0b, required 0 1 0",
               valid_samp, halt, last_samp);
    end else passed++;
    checks++;
    if (samp_idx !== 32'd0 || sample_out !== '0 || tri_out !== '0 || color_out !== '0) begin
      $display("FAIL reset_data: got idx=%0d sample=%h tri00=%0d col0=%0d, required all 0",
               samp_idx, sample_out, tri_out[0][0], color_out[0]);
    end else passed++;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_1spp();
    drive_tri(1, 0, 0, 2048, 1024, 4'b1000);
    model_box(1, 0, 0, 2048, 1024, 1024);
    @(posedge clk);
    #1 valid_tri = 1'b0;
    sub_sample = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (halt !== logic'(k == 6) || valid_samp !== 1'b1) begin
        $display("FAIL 1spp_halt cycle %0d: got halt=%0b valid=%0b, required halt=%0b valid=1",
                 k, halt, valid_samp, k == 6);
      end else passed++;
    end
    @(negedge clk);
    checks++;
    if (valid_samp !== 1'b0 || halt !== 1'b1) begin
      $display("FAIL 1spp_idle: got valid=%0b halt=%0b, required 0 1", valid_samp, halt);
    end else passed++;
    checks++;
    if (exp_q.size() !== 0) $display("FAIL 1spp_drain: got %0d left, required 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_4spp();
    @(posedge clk);
    #1 drive_tri(2, 0, 0, 512, 512, 4'b0100);
    model_box(2, 0, 0, 512, 512, 512);
    @(posedge clk);
    #1 valid_tri = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (valid_samp !== 1'b1) begin
        $display("FAIL 4spp_gap cycle %0d: got valid=%0b, required 1", k, valid_samp);
      end else passed++;
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() !== 0 || valid_samp !== 1'b0) begin
      $display("FAIL 4spp_drain: got %0d left valid=%0b, required 0 0", exp_q.size(), valid_samp);
    end else passed++;
  endtask

  task automatic test_single();
    @(posedge clk);
    #1 drive_tri(3, 1024, 1024, 1024, 1024, 4'b1000);
    model_box(3, 1024, 1024, 1024, 1024, 1024);
    @(posedge clk);
    #1 valid_tri = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_samp !== 1'b1 || last_samp !== 1'b1 || halt !== 1'b1) begin
      $display("FAIL single: got valid=%0b last=%0b halt=%0b, required 1 1 1",
               valid_samp, last_samp, halt);
    end else passed++;
    @(negedge clk);
    checks++;
    if (valid_samp !== 1'b0 || halt !== 1'b1 || exp_q.size() !== 0) begin
      $display("FAIL single_after: got valid=%0b halt=%0b left=%0d, required 0 1 0",
               valid_samp, halt, exp_q.size());
    end else passed++;
  endtask

  task automatic test_empty();
    @(posedge clk);
    #1 drive_tri(4, 2048, 0, 1024, 0, 4'b1000);
    @(posedge clk);
    #1 drive_tri(5, 0, 0, 0, 0, 4'b1000);
    model_box(5, 0, 0, 0, 0, 1024);
    @(negedge clk);
    checks++;
    if (valid_samp !== 1'b0 || halt !== 1'b1) begin
      $display("FAIL empty_drop: got valid=%0b halt=%0b, required 0 1", valid_samp, halt);
    end else passed++;
    @(posedge clk);
    #1 valid_tri = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_samp !== 1'b1) begin
      $display("FAIL empty_next: got valid=%0b, required 1", valid_samp);
    end else passed++;
    @(negedge clk);
    checks++;
    if (valid_samp !== 1'b0 || exp_q.size() !== 0) begin
      $display("FAIL empty_drain: got valid=%0b left=%0d, required 0 0", valid_samp, exp_q.size());
    end else passed++;
  endtask

  task automatic test_back_to_back();
    bit found = 0;
    @(posedge clk);
    #1 drive_tri(6, 0, 0, 512, 512, 4'b0100);
    model_box(6, 0, 0, 512, 512, 512);
    @(posedge clk);
    #1 valid_tri = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (last_samp === 1'b1) found = 1;
    end
    checks++;
    if (!found || halt !== 1'b1) begin
      $display("FAIL b2b_last: got found=%0b halt=%0b, required 1 1", found, halt);
    end else passed++;
    drive_tri(7, 0, 0, 1024, 0, 4'b1000);
    model_box(7, 0, 0, 1024, 0, 1024);
    @(posedge clk);
    #1 valid_tri = 1'b0;
    @(negedge clk);
    checks++;
    if (valid_samp !== 1'b1 || samp_idx !== 32'd0) begin
      $display("FAIL b2b_bubble: got valid=%0b idx=%0d, required 1 0", valid_samp, samp_idx);
    end else passed++;
    repeat (2) @(negedge clk);
    checks++;
    if (valid_samp !== 1'b0 || exp_q.size() !== 0) begin
      $display("FAIL b2b_drain: got valid=%0b left=%0d, required 0 0", valid_samp, exp_q.size());
    end else passed++;
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    @(posedge clk);
    #1 drive_tri(8, 0, 0, 2048, 1024, 4'b1000);
    model_box(8, 0, 0, 2048, 1024, 1024);
    @(posedge clk);
    #1 valid_tri = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (valid_samp === 1'b1 && samp_idx === 32'd2) found = 1;
    end
    rst = 1'b0;
    @(negedge clk);
    exp_q.delete();
    checks++;
    if (!found || valid_samp !== 1'b0 || halt !== 1'b1 || samp_idx !== 32'd0) begin
      $display("FAIL reset_mid: got found=%0b valid=%0b halt=%0b idx=%0d, required 1 0 1 0",
               found, valid_samp, halt, samp_idx);
    end else passed++;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (valid_samp !== 1'b0) begin
      $display("FAIL reset_stale: got valid=%0b, required 0", valid_samp);
    end else passed++;
    @(posedge clk);
    #1 drive_tri(9, 0, 0, 1024, 0, 4'b1000);
    model_box(9, 0, 0, 1024, 0, 1024);
    @(posedge clk);
    #1 valid_tri = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() !== 0) $display("FAIL reset_restart: got %0d left, required 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_boundary();
    @(posedge clk);
    #1 drive_tri(10, 8387584, 0, 8388607, 1024, 4'b1000);
    model_box(10, 8387584, 0, 8388607, 1024, 1024);
    @(posedge clk);
    #1 valid_tri = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() !== 0 || valid_samp !== 1'b0) begin
      $display("FAIL boundary: got left=%0d valid=%0b, required 0 0", exp_q.size(), valid_samp);
    end else passed++;
  endtask

  initial begin
    tri_in = '0;
    color_in = '0;
    box_in = '0;
    valid_tri = 1'b0;
    sub_sample = 4'b1000;
    test_reset();
    test_1spp();
    test_4spp();
    test_single();
    test_empty();
    test_back_to_back();
    test_reset_mid();
    test_boundary();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
